// File: rtl/cpu_lcd_pkg.sv
// rtl/cpu_lcd_pkg.sv - shared opcodes, FSM encoding, ASCII/column constants and mnemonic lookup
package cpu_lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ABS  = 2'd1,
    ST_CONV = 2'd2,
    ST_FILL = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_SUBI  = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_CLEAR = 4'b0110;
  localparam logic [3:0] OP_DISP  = 4'b0111;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_QUEST = 8'h3F;

  localparam logic [4:0] COL_REG    = 5'd13;
  localparam logic [4:0] COL_SIGN   = 5'd26;
  localparam logic [4:0] COL_DIGITS = 5'd27;

  localparam int unsigned CONV_STEPS = 16;
  localparam int unsigned FRAME_LEN  = 32;

  // Five space-padded characters, column 0 in bits [39:32].
  function automatic logic [39:0] mnemonic(input logic [3:0] op);
    logic [39:0] m;
    case (op)
      OP_LOAD:  m = "LOAD ";
      OP_ADD:   m = "ADD  ";
      OP_ADDI:  m = "ADDI ";
      OP_SUB:   m = "SUB  ";
      OP_SUBI:  m = "SUBI ";
      OP_MUL:   m = "MUL  ";
      OP_CLEAR: m = "CLEAR";
      OP_DISP:  m = "DISP ";
      default:  m = {CH_QUEST, CH_QUEST, CH_QUEST, CH_QUEST, CH_SPACE};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative 17-bit to 5-digit BCD double-dabble converter
// load primes the registers, each step performs one add-3/shift iteration.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [16:0] value,
  output logic [19:0] bcd
);

  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [19:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Loading bit 16 straight into the BCD LSB is the first iteration on a
  // zero BCD, so the remaining 16 bits need exactly 16 steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q <= '0;
      bin_q <= '0;
    end else if (load) begin
      bcd_q <= {19'd0, value[16]};
      bin_q <= value[15:0];
    end else if (step) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/cpu_lcd_formatter.sv
// rtl/cpu_lcd_formatter.sv - renders CPU result/dest/opcode into a 2x16 ASCII frame
// CPU_LCD_DOUBLE_BUFFER_EN adds a display buffer refreshed only when a frame completes.
module cpu_lcd_formatter
  import cpu_lcd_pkg::*;
#(
  parameter bit         ZERO_PAD   = 1'b1,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] cpu_result,
  input  logic [3:0]  cpu_dest_addr,
  input  logic [3:0]  cpu_opcode,
  output logic        busy,
  output logic        done,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_char
);

  state_t      state_q, state_d;
  logic [15:0] res_q;
  logic [3:0]  dest_q;
  logic [3:0]  op_q;
  logic        sign_q;
  logic [4:0]  cnt_q;
  logic        done_q;

  logic        accept;
  logic        load_bcd;
  logic        step_bcd;
  logic        wr_en;
  logic        frame_last;

  logic [16:0] magnitude;
  logic [19:0] bcd;
  logic [7:0]  wr_char;
  logic [7:0]  digit_char [5];
  logic [39:0] mn;
  logic        dest_tens;
  logic [3:0]  dest_units;

  logic [7:0]  frame [FRAME_LEN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && !done_q) state_d = ST_ABS;
      ST_ABS:  state_d = ST_CONV;
      ST_CONV: if (cnt_q == 5'(CONV_STEPS - 1)) state_d = ST_FILL;
      ST_FILL: if (cnt_q == 5'(FRAME_LEN - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A start coinciding with the done pulse is dropped, not queued.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    accept     = (state_q == ST_IDLE) && start && !done_q;
    load_bcd   = (state_q == ST_ABS);
    step_bcd   = (state_q == ST_CONV);
    wr_en      = (state_q == ST_FILL);
    frame_last = (state_q == ST_FILL) && (cnt_q == 5'(FRAME_LEN - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q  <= '0;
      dest_q <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        res_q  <= cpu_result;
        dest_q <= cpu_dest_addr;
        op_q   <= cpu_opcode;
      end
      if (load_bcd) begin
        sign_q <= res_q[15];
        cnt_q  <= '0;
      end else if (step_bcd && cnt_q == 5'(CONV_STEPS - 1)) begin
        cnt_q <= '0;
      end else if (step_bcd || wr_en) begin
        cnt_q <= cnt_q + 5'd1;
      end
      done_q <= frame_last;
    end
  end

  // 17-bit negate so that -32768 maps to +32768.
  assign magnitude = res_q[15] ? (17'd0 - {1'b1, res_q}) : {1'b0, res_q};

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_bcd),
    .step    (step_bcd),
    .value   (magnitude),
    .bcd     (bcd)
  );

  always_comb begin
    logic       lead;
    logic [3:0] d;
    lead = 1'b1;
    d    = '0;
    for (int i = 0; i < 5; i++) begin
      d    = bcd[4*(4-i) +: 4];
      lead = lead && (d == 4'd0);
      if (lead && (i != 4) && !ZERO_PAD) digit_char[i] = CH_SPACE;
      else                               digit_char[i] = CH_ZERO + {4'd0, d};
    end
  end

  assign mn         = mnemonic(op_q);
  assign dest_tens  = (dest_q >= 4'd10);
  assign dest_units = dest_tens ? (dest_q - 4'd10) : dest_q;

  always_comb begin
    wr_char = BLANK_CHAR;
    case (cnt_q)
      5'd0:              wr_char = mn[39:32];
      5'd1:              wr_char = mn[31:24];
      5'd2:              wr_char = mn[23:16];
      5'd3:              wr_char = mn[15:8];
      5'd4:              wr_char = mn[7:0];
      COL_REG:           wr_char = CH_R;
      COL_REG + 5'd1:    wr_char = CH_ZERO + {7'd0, dest_tens};
      COL_REG + 5'd2:    wr_char = CH_ZERO + {4'd0, dest_units};
      COL_SIGN:          wr_char = sign_q ? CH_MINUS : CH_PLUS;
      COL_DIGITS:        wr_char = digit_char[0];
      COL_DIGITS + 5'd1: wr_char = digit_char[1];
      COL_DIGITS + 5'd2: wr_char = digit_char[2];
      COL_DIGITS + 5'd3: wr_char = digit_char[3];
      COL_DIGITS + 5'd4: wr_char = digit_char[4];
      default:           wr_char = BLANK_CHAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FRAME_LEN; i++) frame[i] <= BLANK_CHAR;
    end else if (wr_en) begin
      frame[cnt_q] <= wr_char;
    end
  end

`ifdef CPU_LCD_DOUBLE_BUFFER_EN
  logic [7:0] disp [FRAME_LEN];

  // The last column is written on the same edge, so take it from wr_char.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FRAME_LEN; i++) disp[i] <= BLANK_CHAR;
    end else if (frame_last) begin
      for (int i = 0; i < FRAME_LEN - 1; i++) disp[i] <= frame[i];
      disp[FRAME_LEN-1] <= wr_char;
    end
  end

  assign rd_char = disp[rd_addr];
`else
  assign rd_char = frame[rd_addr];
`endif

  assign done = done_q;

endmodule

// File: tb/tb_cpu_lcd_formatter.sv
// tb/tb_cpu_lcd_formatter.sv - self-checking bench for cpu_lcd_formatter (ZERO_PAD=1 and ZERO_PAD=0)
module tb_cpu_lcd_formatter;

`ifdef CPU_LCD_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cpu_result = '0;
  logic [3:0]  cpu_dest_addr = '0;
  logic [3:0]  cpu_opcode = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, done, busy_np, done_np;
  logic [7:0]  rd_char, rd_char_np;

  int    checks = 0;
  int    fails  = 0;
  string exp_p, exp_n;
  string blank_frame = "                                ";
  string names [8] = '{"LOAD ", "ADD  ", "ADDI ", "SUB  ", "SUBI ", "MUL  ", "CLEAR", "DISP "};

  always #10 clk = ~clk;

  cpu_lcd_formatter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cpu_result(cpu_result),
    .cpu_dest_addr(cpu_dest_addr), .cpu_opcode(cpu_opcode), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_char(rd_char)
  );

  cpu_lcd_formatter #(.ZERO_PAD(1'b0)) dut_np (
    .clk(clk), .reset_n(reset_n), .start(start), .cpu_result(cpu_result),
    .cpu_dest_addr(cpu_dest_addr), .cpu_opcode(cpu_opcode), .busy(busy_np), .done(done_np),
    .rd_addr(rd_addr), .rd_char(rd_char_np)
  );

  function automatic string model(logic [15:0] v, logic [3:0] d, logic [3:0] o, bit zp);
    int    sv;
    int    mag;
    string mn, sg, num;
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    if (o[3]) mn = "???? ";
    else      mn = names[o[2:0]];
    if (sv < 0) sg = "-";
    else        sg = "+";
    if (zp) num = $sformatf("%05d", mag);
    else    num = $sformatf("%5d", mag);
    return {mn, "        ", $sformatf("R%02d", d), "          ", sg, num};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      #1;
      chk($sformatf("%s_pad_col%0d", tag, a), {24'd0, rd_char}, {24'd0, exp_p[a]});
      chk($sformatf("%s_nopad_col%0d", tag, a), {24'd0, rd_char_np}, {24'd0, exp_n[a]});
    end
  endtask

  // One request: done expected exactly 49 edges after the accepting edge.
  // A watched address must flip from old to new at the edge that writes it
  // (single buffer) or at the done edge (double buffer).
  task automatic run_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] o,
                           input int glitch_at, input bit start_on_done, input int watch);
    string new_p, new_n;
    int    sw;
    new_p = model(v, d, o, 1'b1);
    new_n = model(v, d, o, 1'b0);
    sw    = DB ? 49 : 18 + watch;
    rd_addr = 5'(watch);
    @(negedge clk);
    cpu_result = v; cpu_dest_addr = d; cpu_opcode = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 49; c++) begin
      @(posedge clk); #1;
      if (glitch_at > 0 && c == glitch_at) begin
        start = 1'b1;
        cpu_result = 16'($urandom); cpu_dest_addr = 4'($urandom); cpu_opcode = 4'($urandom);
      end
      if (glitch_at > 0 && c == glitch_at + 1) start = 1'b0;
      chk($sformatf("done_c%0d", c), {31'd0, done}, (c == 49) ? 32'd1 : 32'd0);
      chk($sformatf("busy_c%0d", c), {31'd0, busy}, (c == 49) ? 32'd0 : 32'd1);
      chk($sformatf("watch%0d_c%0d", watch, c), {24'd0, rd_char},
          {24'd0, (c >= sw) ? new_p[watch] : exp_p[watch]});
      chk($sformatf("watchnp%0d_c%0d", watch, c), {24'd0, rd_char_np},
          {24'd0, (c >= sw) ? new_n[watch] : exp_n[watch]});
      if (c == 49 && start_on_done) start = 1'b1;
    end
    exp_p = new_p;
    exp_n = new_n;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("start_on_done_ignored", {31'd0, busy}, 32'd0);
    check_frame("frame");
  endtask

  initial begin
    exp_p = blank_frame;
    exp_n = blank_frame;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    check_frame("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(16'd1234, 4'd5, 4'b0010, 0, 1'b0, 1);
    run_frame(16'h8000, 4'd15, 4'b0011, 0, 1'b0, 31);
    run_frame(16'hFFF9, 4'd9, 4'b0101, 0, 1'b0, 28);
    run_frame(16'd0, 4'd10, 4'b0110, 10, 1'b0, 13);
    run_frame(16'd9, 4'd0, 4'b0000, 0, 1'b1, 27);
    run_frame(16'd32767, 4'd3, 4'b1011, 0, 1'b0, 0);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    cpu_result = 16'd4321; cpu_dest_addr = 4'd7; cpu_opcode = 4'b0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    exp_p = blank_frame;
    exp_n = blank_frame;
    check_frame("abort");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, done | done_np}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("post_abort_idle", {30'd0, busy, done}, 32'd0);
    end

    run_frame(16'd4321, 4'd7, 4'b0001, 0, 1'b0, 3);
    for (int n = 0; n < 8; n++)
      run_frame(16'($urandom), 4'($urandom), 4'($urandom), 0, 1'b0, int'($urandom_range(0, 31)));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
